// File: rtl/exception_responder.sv
// rtl/exception_responder.sv - prioritised exception capture and flush/redirect recovery sequencer
module exception_responder #(
   parameter logic [31:0] HANDLER_VEC  = 32'h0000_0080,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_exception,
   input  logic             reg_error,
   input  logic [7:0]       alu_status,
   input  logic [1:0]       mem_sig,
   input  logic [31:0]      cur_pc,
   input  logic             eret,
   output logic             flush,
   output logic             pc_redirect,
   output logic [31:0]      redirect_pc,
   output logic [31:0]      epc,
   output logic [2:0]       cause,
   output logic             in_handler,
   output logic             double_fault,
   output logic [CNT_W-1:0] exc_count
);

   typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ENTER, S_HANDLER, S_RETURN} state_t;

   state_t           state_q, state_d;
   logic [2:0]       flush_cnt_q, flush_cnt_d;
   logic [31:0]      epc_q, epc_d;
   logic [2:0]       cause_q, cause_d;
   logic [CNT_W-1:0] exc_count_q, exc_count_d;
   logic             double_fault_q, double_fault_d;
   logic             flush_q, flush_d;
   logic             pc_redirect_q, pc_redirect_d;
   logic             in_handler_q, in_handler_d;
   logic             misalign_err;
   logic             err;
   logic [2:0]       code;

   assign misalign_err = alu_status[3] & (|mem_sig);
   assign err = pc_exception | reg_error | alu_status[6] | misalign_err | alu_status[2];

   always_comb begin
      code = 3'd0;
      if (pc_exception)       code = 3'd1;
      else if (reg_error)     code = 3'd2;
      else if (alu_status[6]) code = 3'd3;
      else if (misalign_err)  code = 3'd4;
      else if (alu_status[2]) code = 3'd5;
   end

   always_comb begin
      state_d        = state_q;
      flush_cnt_d    = flush_cnt_q;
      epc_d          = epc_q;
      cause_d        = cause_q;
      exc_count_d    = exc_count_q;
      double_fault_d = double_fault_q;
      case (state_q)
         S_IDLE: begin
            if (err) begin
               state_d     = S_FLUSH;
               epc_d       = cur_pc;
               cause_d     = code;
               flush_cnt_d = 3'(FLUSH_CYCLES);
               if (exc_count_q != {CNT_W{1'b1}}) exc_count_d = exc_count_q + CNT_W'(1);
            end
         end
         S_FLUSH: begin
            if (flush_cnt_q <= 3'd1) state_d = S_ENTER;
            else flush_cnt_d = flush_cnt_q - 3'd1;
         end
         S_ENTER:   state_d = S_HANDLER;
         S_HANDLER: if (eret) state_d = S_RETURN;
         S_RETURN:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // Errors outside IDLE only mark the double fault; the running sequence is untouched.
      if (err && state_q != S_IDLE) double_fault_d = 1'b1;

      flush_d       = (state_d == S_FLUSH) || (state_d == S_RETURN);
      pc_redirect_d = (state_d == S_ENTER) || (state_d == S_RETURN);
      in_handler_d  = (state_d == S_ENTER) || (state_d == S_HANDLER) || (state_d == S_RETURN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         flush_cnt_q    <= 3'd0;
         epc_q          <= 32'd0;
         cause_q        <= 3'd0;
         exc_count_q    <= '0;
         double_fault_q <= 1'b0;
         flush_q        <= 1'b0;
         pc_redirect_q  <= 1'b0;
         in_handler_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         flush_cnt_q    <= flush_cnt_d;
         epc_q          <= epc_d;
         cause_q        <= cause_d;
         exc_count_q    <= exc_count_d;
         double_fault_q <= double_fault_d;
         flush_q        <= flush_d;
         pc_redirect_q  <= pc_redirect_d;
         in_handler_q   <= in_handler_d;
      end
   end

   always_comb begin
      redirect_pc = 32'd0;
      if (state_q == S_ENTER)       redirect_pc = HANDLER_VEC;
      else if (state_q == S_RETURN) redirect_pc = epc_q;
   end

   assign flush        = flush_q;
   assign pc_redirect  = pc_redirect_q;
   assign epc          = epc_q;
   assign cause        = cause_q;
   assign in_handler   = in_handler_q;
   assign double_fault = double_fault_q;
   assign exc_count    = exc_count_q;

endmodule

// File: tb/tb_exception_responder.sv
// tb/tb_exception_responder.sv - directed self-checking bench for exception_responder
module tb_exception_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_exception;
   logic        reg_error;
   logic [7:0]  alu_status;
   logic [1:0]  mem_sig;
   logic [31:0] cur_pc;
   logic        eret;
   logic        flush;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic [2:0]  cause;
   logic        in_handler;
   logic        double_fault;
   logic [7:0]  exc_count;

   int tests = 0;
   int fails = 0;

   exception_responder dut (
      .clk(clk), .rst(rst), .pc_exception(pc_exception), .reg_error(reg_error),
      .alu_status(alu_status), .mem_sig(mem_sig), .cur_pc(cur_pc), .eret(eret),
      .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc),
      .cause(cause), .in_handler(in_handler), .double_fault(double_fault), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      pc_exception = 1'b0; reg_error = 1'b0; alu_status = 8'h00; mem_sig = 2'b00; eret = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".flush"}, 32'(flush), 32'd0);
      chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'd0);
      chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
      chk({tag, ".epc"}, epc, 32'd0);
      chk({tag, ".cause"}, 32'(cause), 32'd0);
      chk({tag, ".in_handler"}, 32'(in_handler), 32'd0);
      chk({tag, ".double_fault"}, 32'(double_fault), 32'd0);
      chk({tag, ".exc_count"}, 32'(exc_count), 32'd0);
   endtask

   // Full exception round trip driven by a PC fault: detect, 2 flush, enter, handler, return, idle.
   task automatic do_exc(input logic [31:0] pc);
      pc_exception = 1'b1; cur_pc = pc;
      step(); clear_in();
      step(); step(); step();
      eret = 1'b1; step(); eret = 1'b0;
      step();
   endtask

   initial begin
      clear_in(); cur_pc = 32'd0; rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk_all_zero("reset");

      // Overflow exception with full latency profile and return.
      alu_status = 8'h40; cur_pc = 32'h0000_0010;
      step(); clear_in();
      chk("ovf.cause", 32'(cause), 32'd3);
      chk("ovf.epc", epc, 32'h10);
      chk("ovf.count", 32'(exc_count), 32'd1);
      chk("ovf.flush1", 32'(flush), 32'd1);
      chk("ovf.redir1", 32'(pc_redirect), 32'd0);
      step();
      chk("ovf.flush2", 32'(flush), 32'd1);
      step();
      chk("ovf.flush3", 32'(flush), 32'd0);
      chk("ovf.enter_redir", 32'(pc_redirect), 32'd1);
      chk("ovf.enter_pc", redirect_pc, 32'h80);
      step();
      chk("ovf.hdl_inh", 32'(in_handler), 32'd1);
      chk("ovf.hdl_redir", 32'(pc_redirect), 32'd0);
      chk("ovf.hdl_pc", redirect_pc, 32'd0);
      eret = 1'b1; step(); eret = 1'b0;
      chk("ovf.ret_redir", 32'(pc_redirect), 32'd1);
      chk("ovf.ret_pc", redirect_pc, 32'h10);
      chk("ovf.ret_flush", 32'(flush), 32'd1);
      chk("ovf.ret_inh", 32'(in_handler), 32'd1);
      step();
      chk("ovf.idle_inh", 32'(in_handler), 32'd0);
      chk("ovf.idle_redir", 32'(pc_redirect), 32'd0);
      chk("ovf.idle_flush", 32'(flush), 32'd0);
      chk("ovf.no_dbl", 32'(double_fault), 32'd0);

      // Simultaneous sources: PC fault wins; eret during ENTER is ignored.
      pc_exception = 1'b1; reg_error = 1'b1; alu_status = 8'h44; cur_pc = 32'h0000_0020;
      step(); clear_in();
      chk("prio.cause", 32'(cause), 32'd1);
      chk("prio.epc", epc, 32'h20);
      chk("prio.count", 32'(exc_count), 32'd2);
      step(); step();
      chk("prio.enter", 32'(pc_redirect), 32'd1);
      eret = 1'b1; step(); eret = 1'b0;
      chk("eret_enter.redir", 32'(pc_redirect), 32'd0);
      chk("eret_enter.inh", 32'(in_handler), 32'd1);
      step();
      chk("eret_enter.still_hdl", 32'(pc_redirect), 32'd0);
      chk("eret_enter.still_inh", 32'(in_handler), 32'd1);
      eret = 1'b1; step(); eret = 1'b0;
      chk("prio.ret_pc", redirect_pc, 32'h20);
      step();

      // Misaligned flag only counts with a memory access in flight.
      alu_status = 8'h08; mem_sig = 2'b00; cur_pc = 32'h0000_0030;
      step();
      chk("mis_nomem.flush", 32'(flush), 32'd0);
      chk("mis_nomem.count", 32'(exc_count), 32'd2);
      chk("mis_nomem.cause", 32'(cause), 32'd1);
      mem_sig = 2'b01;
      step(); clear_in();
      chk("mis.cause", 32'(cause), 32'd4);
      chk("mis.epc", epc, 32'h30);
      chk("mis.count", 32'(exc_count), 32'd3);

      // Error during FLUSH: double fault, captured state held, sequence unaffected.
      reg_error = 1'b1; cur_pc = 32'h0000_00AA;
      step(); clear_in();
      chk("dbl.flag", 32'(double_fault), 32'd1);
      chk("dbl.cause", 32'(cause), 32'd4);
      chk("dbl.epc", epc, 32'h30);
      chk("dbl.count", 32'(exc_count), 32'd3);
      chk("dbl.flush", 32'(flush), 32'd1);
      step();
      chk("dbl.enter_redir", 32'(pc_redirect), 32'd1);
      chk("dbl.enter_pc", redirect_pc, 32'h80);
      step();
      eret = 1'b1; step(); eret = 1'b0;
      chk("dbl.ret_pc", redirect_pc, 32'h30);

      // Error in RETURN is rejected; the same error in the following IDLE cycle is taken.
      alu_status = 8'h04; cur_pc = 32'h0000_0040;
      step();
      chk("ret_err.flush", 32'(flush), 32'd0);
      chk("ret_err.cause", 32'(cause), 32'd4);
      chk("ret_err.count", 32'(exc_count), 32'd3);
      chk("ret_err.dbl", 32'(double_fault), 32'd1);
      cur_pc = 32'h0000_0050;
      step(); clear_in();
      chk("div0.cause", 32'(cause), 32'd5);
      chk("div0.epc", epc, 32'h50);
      chk("div0.count", 32'(exc_count), 32'd4);
      step(); step(); step();
      chk("div0.hdl_inh", 32'(in_handler), 32'd1);

      // Reset inside HANDLER, then a stray eret must not redirect.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all_zero("midrst");
      eret = 1'b1; step(); eret = 1'b0;
      chk("eret_idle.redir", 32'(pc_redirect), 32'd0);
      chk("eret_idle.inh", 32'(in_handler), 32'd0);
      step();
      chk("eret_idle.redir2", 32'(pc_redirect), 32'd0);

      // Counter saturation.
      for (int i = 0; i < 255; i++) do_exc(32'h100 + 32'(i));
      chk("sat.count255", 32'(exc_count), 32'd255);
      do_exc(32'h0000_0F00);
      chk("sat.count_hold", 32'(exc_count), 32'd255);
      chk("sat.epc", epc, 32'h0F00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/exception_responder.md
Name: exception_responder

Overview:
- Consumer side of the exception-signalling interface. It takes the same raw error sources the datapath qualifies (PC fault, register-file error, ALU status, memory-access type).
- Arbitrates those sources by priority and latches the exception cause and faulting PC (EPC).
- Runs a recovery sequence: pipeline flush, redirect to the handler vector, wait for return, then redirect back to EPC.
- Sits beside the PC/fetch control. It owns the pc_redirect and flush lines used during exception entry and exit.

Parameters:
HANDLER_VEC, 32'h0000_0080, PC value driven on handler entry
FLUSH_CYCLES, 2, number of cycles flush is held asserted (1..7)
CNT_W, 8, width of the saturating exception counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
pc_exception  input  1  fetch PC fault
reg_error  input  1  register-file access error
alu_status  input  8  ALU flags: [6] overflow, [3] misaligned address, [2] divide-by-zero
mem_sig  input  2  memory access type; nonzero means load/store in flight
cur_pc  input  32  PC of the instruction in the stage that raised the error
eret  input  1  handler return request, single-cycle pulse
flush  output  1  squash in-flight instructions
pc_redirect  output  1  fetch must load redirect_pc this cycle
redirect_pc  output  32  target PC when pc_redirect is high
epc  output  32  latched faulting PC
cause  output  3  latched cause code
in_handler  output  1  high from redirect until return completes
double_fault  output  1  sticky; an error arrived while not IDLE
exc_count  output  CNT_W  saturating count of accepted exceptions

Behaviour:
- Error detect: err = pc_exception | reg_error | alu_status[6] | (alu_status[3] & |mem_sig) | alu_status[2].
- Cause priority, highest first:
  - pc_exception = 3'd1
  - reg_error = 3'd2
  - overflow = 3'd3
  - misaligned with memory access = 3'd4
  - div0 = 3'd5
  - No error = 3'd0.
- FSM states: IDLE, FLUSH, ENTER, HANDLER, RETURN.
- IDLE:
  - When err = 1: latch epc <= cur_pc and cause <= the priority code on the same edge.
  - Increment exc_count, saturating at all-ones.
  - Load flush counter with FLUSH_CYCLES; go to FLUSH.
- FLUSH:
  - flush = 1 for exactly FLUSH_CYCLES cycles, starting the cycle after detection.
  - Then go to ENTER.
- ENTER: one cycle, pc_redirect = 1 and redirect_pc = HANDLER_VEC; go to HANDLER.
- HANDLER:
  - in_handler = 1; wait for eret.
  - On eret go to RETURN.
- RETURN:
  - One cycle, pc_redirect = 1, redirect_pc = epc, flush = 1, in_handler = 1.
  - Then go to IDLE; in_handler drops the next cycle.
- redirect_pc = 0 whenever pc_redirect = 0.
- err while not IDLE:
  - Set double_fault (sticky until rst).
  - Do not update epc, cause or exc_count; the sequence continues unaffected.
- eret outside HANDLER is ignored.
- eret in the same cycle as ENTER is ignored. Only eret seen while in HANDLER counts.
- err in RETURN counts as a double fault. It is not accepted as a new exception.
- An error in the first IDLE cycle after RETURN is accepted normally.
- Reset:
  - State IDLE.
  - flush = 0, pc_redirect = 0, redirect_pc = 0.
  - epc = 0, cause = 0, in_handler = 0, double_fault = 0, exc_count = 0.
- Reset mid-sequence aborts immediately to these values on the next edge; no redirect is issued.
- Latency: error at cycle N gives flush at N+1..N+FLUSH_CYCLES and the handler redirect at N+FLUSH_CYCLES+1.
- All outputs are registered except redirect_pc, which is a decode of state and epc.

Test Plan:
- Reset, then apply alu_status=8'h40 with cur_pc=32'h0000_0010 -> cause=3, epc=0x10, flush high for 2 cycles, pc_redirect with redirect_pc=0x80 on cycle 3, in_handler=1, exc_count=1.
- Apply pc_exception=1, reg_error=1 and alu_status=8'h44 together -> cause=1 (priority).
- Apply alu_status=8'h08 with mem_sig=0 -> no exception. Then the same with mem_sig=2'b01 -> cause=4.
- While in HANDLER apply eret -> next cycle pc_redirect=1, redirect_pc=epc, flush=1; then IDLE and in_handler=0.
- While in FLUSH or HANDLER apply reg_error -> double_fault=1; epc, cause and exc_count unchanged; sequence completes normally.
- Hold rst during HANDLER -> all outputs return to 0. Apply eret after reset -> no redirect. Force exc_count to 255 and raise one more error -> count stays 255.
